step_mod_counter: RTL and testbench

Parametrised up/down counter with programmable modulus, variable step, wrap or saturate mode, synchronous clear/load, a one-cycle carry/borrow pulse and a sticky overflow flag. It is the general-purpose successor to the team's fixed-step N-bit up/down counter. It serves timers, address generators and rate dividers that need a range other than 0..2^N-1 or a step other than 1.

---
 rtl/step_mod_counter.sv | 93 +++++++++
 tb/tb_step_mod_counter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_mod_counter.sv
// Up/down counter over 0..limit with a variable step, wrap or saturate at the
// range ends, a one-cycle carry pulse per range event and a sticky overflow flag.
module step_mod_counter #(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clear,
    input  logic              load,
    input  logic [N-1:0]      load_val,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic [N-1:0]      limit,
    input  logic              sat_mode,
    output logic [N-1:0]      count_out,
    output logic              carry_out,
    output logic              at_term,
    output logic              ovf_sticky
);

    logic [N-1:0] step_ext;
    logic [N-1:0] s_eff;
    logic [N-1:0] load_clamped;
    logic [N:0]   lim_p1;
    logic [N:0]   sum_up;
    logic [N:0]   sum_down_wrap;
    logic [N-1:0] nxt_count;
    logic         nxt_carry;

    assign step_ext      = N'(step);
    assign s_eff         = (step_ext > limit) ? limit : step_ext;
    assign load_clamped  = (load_val > limit) ? limit : load_val;
    assign lim_p1        = {1'b0, limit} + {{N{1'b0}}, 1'b1};
    // N+1-bit sums so neither direction can overflow before the range check
    assign sum_up        = {1'b0, count_out} + {1'b0, s_eff};
    assign sum_down_wrap = {1'b0, count_out} + lim_p1 - {1'b0, s_eff};

    always_comb begin
        nxt_count = count_out;
        nxt_carry = 1'b0;
        if (step != '0) begin
            if (count_out > limit) begin
                nxt_count = up_down ? '0 : limit;
                nxt_carry = 1'b1;
            end else if (limit == '0) begin
                // single-value range: any nonzero step leaves it
                nxt_count = '0;
                nxt_carry = 1'b1;
            end else if (up_down) begin
                if (sum_up > {1'b0, limit}) begin
                    nxt_count = sat_mode ? limit : N'(sum_up - lim_p1);
                    nxt_carry = 1'b1;
                end else begin
                    nxt_count = sum_up[N-1:0];
                end
            end else begin
                if (s_eff > count_out) begin
                    nxt_count = sat_mode ? '0 : sum_down_wrap[N-1:0];
                    nxt_carry = 1'b1;
                end else begin
                    nxt_count = count_out - s_eff;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_out  <= '0;
            carry_out  <= 1'b0;
            ovf_sticky <= 1'b0;
        end else if (clear) begin
            count_out  <= '0;
            carry_out  <= 1'b0;
            ovf_sticky <= 1'b0;
        end else if (load) begin
            count_out  <= load_clamped;
            carry_out  <= 1'b0;
        end else if (en) begin
            count_out  <= nxt_count;
            carry_out  <= nxt_carry;
            if (nxt_carry)
                ovf_sticky <= 1'b1;
        end else begin
            carry_out  <= 1'b0;
        end
    end

    assign at_term = up_down ? (count_out == limit) : (count_out == '0);

endmodule

// File: tb/tb_step_mod_counter.sv
// Checks step_mod_counter (N=4) against an integer model of the counting rules,
// with directed scenarios pinned by literal values and a randomized run.
module tb_step_mod_counter;
    localparam int N = 4;
    localparam int STEP_W = 4;

    logic clk = 0;
    logic rst_n = 0;
    logic en = 0, clear = 0, load = 0, up_down = 1, sat_mode = 0;
    logic [N-1:0] load_val = '0, limit = 4'd15;
    logic [STEP_W-1:0] step = 4'd1;
    logic [N-1:0] count_out;
    logic carry_out, at_term, ovf_sticky;

    int n_cmp = 0;
    int n_err = 0;

    int m_count = 0, m_carry = 0, m_ovf = 0;

    step_mod_counter #(.N(N), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .load(load),
        .load_val(load_val), .up_down(up_down), .step(step), .limit(limit),
        .sat_mode(sat_mode), .count_out(count_out), .carry_out(carry_out),
        .at_term(at_term), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: range 0..lim, arithmetic on plain ints
    always @(posedge clk or negedge rst_n) begin
        int lim, s, t, c, cy;
        if (!rst_n) begin
            m_count = 0; m_carry = 0; m_ovf = 0;
        end else if (clear) begin
            m_count = 0; m_carry = 0; m_ovf = 0;
        end else if (load) begin
            lim = int'(limit);
            m_count = (int'(load_val) > lim) ? lim : int'(load_val);
            m_carry = 0;
        end else if (en) begin
            lim = int'(limit);
            c = m_count;
            cy = 0;
            if (step == 0) begin
                cy = 0;
            end else if (c > lim) begin
                c = up_down ? 0 : lim;
                cy = 1;
            end else if (lim == 0) begin
                c = 0;
                cy = 1;
            end else begin
                s = (int'(step) > lim) ? lim : int'(step);
                if (up_down) begin
                    t = c + s;
                    if (t > lim) begin
                        c = sat_mode ? lim : t - (lim + 1);
                        cy = 1;
                    end else c = t;
                end else begin
                    t = c - s;
                    if (t < 0) begin
                        c = sat_mode ? 0 : t + lim + 1;
                        cy = 1;
                    end else c = t;
                end
            end
            m_count = c;
            m_carry = cy;
            if (cy) m_ovf = 1;
        end else begin
            m_carry = 0;
        end
    end

    always @(negedge clk) begin
        chk("model_count", int'(count_out), m_count);
        chk("model_carry", int'(carry_out), m_carry);
        chk("model_ovf", int'(ovf_sticky), m_ovf);
        chk("model_at_term", int'(at_term),
            up_down ? int'(m_count == int'(limit)) : int'(m_count == 0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        load = 1; en = 0; load_val = N'(v);
        tick();
        load = 0;
    endtask

    initial begin
        #12;
        chk("reset_count", int'(count_out), 0);
        chk("reset_ovf", int'(ovf_sticky), 0);
        tick();
        rst_n = 1;
        tick();

        // up wrap
        limit = 9; step = 3; sat_mode = 0; up_down = 1;
        do_load(8);
        chk("load8", int'(count_out), 8);
        en = 1;
        tick();
        chk("upwrap_count", int'(count_out), 1);
        chk("upwrap_carry", int'(carry_out), 1);
        chk("upwrap_ovf", int'(ovf_sticky), 1);
        tick();
        chk("upwrap_next", int'(count_out), 4);
        chk("upwrap_next_carry", int'(carry_out), 0);
        tick();
        en = 0;
        chk("count7", int'(count_out), 7);

        // async reset between edges
        #2 rst_n = 0;
        #1;
        chk("async_count", int'(count_out), 0);
        chk("async_carry", int'(carry_out), 0);
        chk("async_ovf", int'(ovf_sticky), 0);
        en = 1;
        tick();
        tick();
        chk("reset_hold", int'(count_out), 0);
        rst_n = 1;
        en = 0;

        // up saturate
        sat_mode = 1;
        do_load(8);
        en = 1;
        tick();
        chk("upsat_count", int'(count_out), 9);
        chk("upsat_carry", int'(carry_out), 1);
        tick();
        chk("upsat_again", int'(count_out), 9);
        chk("upsat_again_carry", int'(carry_out), 1);
        step = 0;
        tick();
        chk("upsat_hold_carry", int'(carry_out), 0);
        chk("upsat_at_term", int'(at_term), 1);
        step = 3;

        // down wrap / saturate
        sat_mode = 0; up_down = 0;
        do_load(1);
        en = 1;
        tick();
        chk("dnwrap_count", int'(count_out), 8);
        chk("dnwrap_carry", int'(carry_out), 1);
        sat_mode = 1;
        do_load(1);
        en = 1;
        tick();
        chk("dnsat_count", int'(count_out), 0);
        chk("dnsat_carry", int'(carry_out), 1);
        chk("dnsat_at_term", int'(at_term), 1);

        // priority and clamping
        clear = 1; load = 1; load_val = 5; en = 1;
        tick();
        clear = 0; load = 0; en = 0;
        chk("prio_count", int'(count_out), 0);
        chk("prio_ovf", int'(ovf_sticky), 0);
        do_load(12);
        chk("load_clamp", int'(count_out), 9);
        up_down = 1; step = 3; load = 1; load_val = 3; en = 1;
        tick();
        load = 0; en = 0;
        chk("load_over_en", int'(count_out), 3);

        // limit lowered under the count
        limit = 15; sat_mode = 0; step = 1; up_down = 1;
        do_load(7);
        limit = 5; en = 1;
        tick();
        chk("lowlim_up", int'(count_out), 0);
        chk("lowlim_up_carry", int'(carry_out), 1);
        limit = 15;
        do_load(7);
        limit = 5; up_down = 0; en = 1;
        tick();
        chk("lowlim_dn", int'(count_out), 5);
        chk("lowlim_dn_carry", int'(carry_out), 1);
        limit = 9; up_down = 1;
        do_load(0);
        step = 12; en = 1;
        tick();
        chk("step_clamp", int'(count_out), 9);
        chk("step_clamp_carry", int'(carry_out), 0);

        // single-value range
        limit = 0; step = 2;
        tick();
        chk("lim0_count", int'(count_out), 0);
        chk("lim0_carry", int'(carry_out), 1);

        // randomized run
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            clear    = ($urandom_range(0, 31) == 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = N'($urandom_range(0, 15));
            up_down  = $urandom_range(0, 1) != 0;
            step     = STEP_W'($urandom_range(0, 15));
            sat_mode = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 15) == 0)
                limit = N'($urandom_range(0, 15));
            tick();
        end
        en = 0; clear = 0; load = 0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
